// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: iterative 4-digit packed BCD to unsigned binary converter.
// One digit per cycle, most significant digit first (acc = acc*10 + digit),
// valid/ready handshake on both input and output sides.
// Optional macro BCD_CHECK_EN: flags any non-BCD digit via out_err and forces
// binary/out_ovf to zero for that result; undefined leaves out_err tied low and
// uses digits above 9 as raw weights.
module bcd_to_binary_seq #(
    parameter int unsigned OUT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       thous,
    input  logic [3:0]       hund,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] binary,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int unsigned ACC_W = 14;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned NDIG  = 4;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned REG_W = DIG_W * NDIG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [REG_W-1:0]   digits_q, digits_n;
    logic [ACC_W-1:0]   acc_q, acc_n;
    logic [ACC_W-1:0]   acc_step;
    logic [ACC_W-1:0]   acc_hi;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               in_ready_n;
    logic               out_valid_n;
    logic [OUT_W-1:0]   binary_n;
    logic               out_ovf_n;

`ifdef BCD_CHECK_EN
    logic err_q, err_n;
    logic out_err_q, out_err_n;
    logic bad_digit;
`endif

    // One multiply-by-ten-and-add step; the digit register shifts so the top nibble is current
    always_comb begin
        acc_step = ACC_W'(acc_q << 3) + ACC_W'(acc_q << 1)
                 + ACC_W'(digits_q[REG_W-1 -: DIG_W]);
        acc_hi   = acc_step >> OUT_W;
    end

`ifdef BCD_CHECK_EN
    // Any captured digit above nine poisons the result
    always_comb begin
        bad_digit = (thous > 4'd9) || (hund > 4'd9) || (tens > 4'd9) || (ones > 4'd9);
    end
`endif

    // Next-state and datapath/output next values
    always_comb begin
        state_n     = state_q;
        digits_n    = digits_q;
        acc_n       = acc_q;
        cnt_n       = cnt_q;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        binary_n    = binary;
        out_ovf_n   = out_ovf;
`ifdef BCD_CHECK_EN
        err_n       = err_q;
        out_err_n   = out_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    digits_n   = {thous, hund, tens, ones};
                    acc_n      = '0;
                    cnt_n      = '0;
                    in_ready_n = 1'b0;
                    state_n    = CONV;
`ifdef BCD_CHECK_EN
                    err_n      = bad_digit;
`endif
                end
            end
            CONV: begin
                digits_n = {digits_q[REG_W-DIG_W-1:0], {DIG_W{1'b0}}};
                acc_n    = acc_step;
                cnt_n    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_n     = DONE;
                    out_valid_n = 1'b1;
                    binary_n    = acc_step[OUT_W-1:0];
                    out_ovf_n   = (OUT_W < ACC_W) && (acc_hi != '0);
`ifdef BCD_CHECK_EN
                    out_err_n   = err_q;
                    if (err_q) begin
                        binary_n  = '0;
                        out_ovf_n = 1'b0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            digits_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            binary    <= '0;
            out_ovf   <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            digits_q  <= digits_n;
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            binary    <= binary_n;
            out_ovf   <= out_ovf_n;
`ifdef BCD_CHECK_EN
            err_q     <= err_n;
            out_err_q <= out_err_n;
`endif
        end
    end

`ifdef BCD_CHECK_EN
    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: two instances (OUT_W=14 and OUT_W=12) share the
// input side so every vector checks both full-width and truncated results.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  thous, hund, tens, ones;
    logic        out_ready;

    logic        rdy14, ov14, ovf14, err14;
    logic [13:0] bin14;
    logic        rdy12, ov12, ovf12, err12;
    logic [11:0] bin12;

    int total = 0;
    int bad   = 0;

`ifdef BCD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  th, hu, te, on;
        bit          raw;
        logic [13:0] e14;
        logic [11:0] e12;
        bit          o12;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    bcd_to_binary_seq #(.OUT_W(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy14),
        .thous(thous), .hund(hund), .tens(tens), .ones(ones),
        .out_valid(ov14), .out_ready(out_ready), .binary(bin14),
        .out_ovf(ovf14), .out_err(err14)
    );

    bcd_to_binary_seq #(.OUT_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy12),
        .thous(thous), .hund(hund), .tens(tens), .ones(ones),
        .out_valid(ov12), .out_ready(out_ready), .binary(bin12),
        .out_ovf(ovf12), .out_err(err12)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Called #1 after an edge with in_ready expected high; accepts at the next edge
    task automatic do_conv(input vec_t v, input int hold);
        int  lat;
        bit  e_err;
        int  x14, x12, xo12;
        e_err = CHK && v.raw;
        x14   = e_err ? 0 : int'(v.e14);
        x12   = e_err ? 0 : int'(v.e12);
        xo12  = e_err ? 0 : int'(v.o12);

        chk("in_ready_before_accept", int'(rdy14), 1);
        thous = v.th; hund = v.hu; tens = v.te; ones = v.on;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        // digits may change freely after capture; in_valid pulses must be ignored
        thous = 4'h3; hund = 4'h3; tens = 4'h3; ones = 4'h3;
        in_valid = 1'b1;
        lat = 0;
        while (!ov14 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency_edges", lat, 4);
        chk("in_ready_in_done", int'(rdy14), 0);
        chk("out_valid12", int'(ov12), 1);
        chk("binary14", int'(bin14), x14);
        chk("ovf14", int'(ovf14), 0);
        chk("err14", int'(err14), int'(e_err));
        chk("binary12", int'(bin12), x12);
        chk("ovf12", int'(ovf12), xo12);
        chk("err12", int'(err12), int'(e_err));
        for (int k = 0; k < hold; k++) begin
            in_valid = (k != hold - 1);
            @(posedge clk); #1;
            chk("hold_out_valid", int'(ov14), 1);
            chk("hold_binary", int'(bin14), x14);
            chk("hold_in_ready", int'(rdy14), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_after_hs", int'(ov14), 0);
        chk("in_ready_after_hs", int'(rdy14), 1);
        chk("binary_retained", int'(bin14), x14);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{th:4'd1, hu:4'd2, te:4'd3, on:4'd4, raw:1'b0, e14:14'd1234,  e12:12'd1234,  o12:1'b0};
        vecs[1] = '{th:4'd9, hu:4'd9, te:4'd9, on:4'd9, raw:1'b0, e14:14'h270F,  e12:12'h70F,   o12:1'b1};
        vecs[2] = '{th:4'd0, hu:4'd0, te:4'd0, on:4'd0, raw:1'b0, e14:14'd0,     e12:12'd0,     o12:1'b0};
        vecs[3] = '{th:4'd4, hu:4'd0, te:4'd9, on:4'd6, raw:1'b0, e14:14'h1000,  e12:12'h000,   o12:1'b1};
        vecs[4] = '{th:4'd4, hu:4'd0, te:4'd9, on:4'd5, raw:1'b0, e14:14'h0FFF,  e12:12'hFFF,   o12:1'b0};
        vecs[5] = '{th:4'd0, hu:4'd0, te:4'hC, on:4'd0, raw:1'b1, e14:14'd120,   e12:12'd120,   o12:1'b0};
        // 16665 wraps mod 16384 to 281
        vecs[6] = '{th:4'hF, hu:4'hF, te:4'hF, on:4'hF, raw:1'b1, e14:14'd281,   e12:12'd281,   o12:1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        thous = 4'd0; hund = 4'd0; tens = 4'd0; ones = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(rdy14), 1);
        chk("rst_out_valid", int'(ov14), 0);
        chk("rst_binary", int'(bin14), 0);
        chk("rst_ovf", int'(ovf12), 0);
        chk("rst_err", int'(err14), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back table conversions
        for (int i = 0; i < 7; i++) do_conv(vecs[i], 0);

        // backpressure: result held for three cycles
        v = '{th:4'd0, hu:4'd0, te:4'd5, on:4'd9, raw:1'b0, e14:14'd59, e12:12'd59, o12:1'b0};
        do_conv(v, 3);

        // reset in the middle of a conversion after two digits
        v = vecs[0];
        do_conv(v, 0);
        thous = 4'd1; hund = 4'd2; tens = 4'd3; ones = 4'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(ov14), 0);
        chk("midrst_binary", int'(bin14), 0);
        chk("midrst_in_ready", int'(rdy14), 1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_out_valid", int'(ov14), 0);
        v = '{th:4'd0, hu:4'd0, te:4'd0, on:4'd7, raw:1'b0, e14:14'd7, e12:12'd7, o12:1'b0};
        do_conv(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
